// File: rtl/signed_divider.sv
// Multi-cycle signed divider: restoring radix-2 division on operand magnitudes,
// one quotient bit per clock, with the signs applied in a final fix-up cycle.
module signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, dmag_reg;
    logic             sign_q_reg, sign_r_reg, zero_reg;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   partial;
    logic             fits;
    logic [WIDTH-1:0] rem_step, quo_step;

    // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is
    // exactly right when the result is read as unsigned.
    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    // One restoring step: shift {R,Q} left, subtract |b| when it fits.
    always_comb begin
        partial  = {rem_reg, quo_reg[WIDTH-1]};
        fits     = (partial >= {1'b0, dmag_reg});
        rem_step = fits ? (partial[WIDTH-1:0] - dmag_reg) : partial[WIDTH-1:0];
        quo_step = {quo_reg[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count_reg == CW'(1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == CALC) || (state_reg == FIX);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dmag_reg    <= '0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            zero_reg    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rem_reg    <= '0;
                        quo_reg    <= a_mag;
                        dmag_reg   <= b_mag;
                        sign_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_reg <= dividend[WIDTH-1];
                        zero_reg   <= (divisor == '0);
                        count_reg  <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    rem_reg   <= rem_step;
                    quo_reg   <= quo_step;
                    count_reg <= count_reg - CW'(1);
                end
                FIX: begin
                    // With |b|=0 the loop leaves R=|a|, so the remainder still
                    // comes out equal to the dividend; only q needs overriding.
                    quotient    <= zero_reg ? '1 : (sign_q_reg ? -quo_reg : quo_reg);
                    remainder   <= sign_r_reg ? -rem_reg : rem_reg;
                    div_by_zero <= zero_reg;
                end
                default: ;
            endcase
        end
    end

endmodule
